rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares the single combinational program-ROM read port between two requesters: port 0 (CPU instruction/data fetch) and port 1 (debug/display scanner that walks ROM contents).
- Sits between the CPU, the scanner and the ROM inside the motherboard.
- Serialises reads with a req/gnt/rvalid handshake, registers ROM data and flags out-of-range addresses.

Parameters:
ADDR_WIDTH, 4, ROM address width; ROM depth is 2**ADDR_WIDTH words
DATA_WIDTH, 16, ROM word width

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
req0  input  1  port 0 read request; held high with addr0 stable until gnt0
addr0  input  8  port 0 byte-wide address
gnt0  output  1  one-cycle pulse: port 0 request accepted
rvalid0  output  1  one-cycle pulse: rdata0/err0 valid
rdata0  output  DATA_WIDTH  port 0 read data
err0  output  1  valid with rvalid0: address out of range
req1  input  1  port 1 read request, same rules as port 0
addr1  input  8  port 1 address
gnt1  output  1  port 1 accept pulse
rvalid1  output  1  port 1 data-valid pulse
rdata1  output  DATA_WIDTH  port 1 read data
err1  output  1  port 1 out-of-range flag
rom_address  output  ADDR_WIDTH  address driven to ROM
rom_read_value  input  DATA_WIDTH  combinational ROM data
busy  output  1  high while a transaction is in flight (state != IDLE)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all gnt*/rvalid*/err*=0, rdata*=0, rom_address=0, busy=0, latched owner=0. An in-flight transaction is aborted; no rvalid is produced for it after reset release.
- FSM: IDLE -> GRANT -> READ -> IDLE.
- IDLE: sample req0/req1. If none, stay. Otherwise select winner (see arbitration), latch its address and owner, go GRANT.
- GRANT: gnt<owner>=1 for exactly this cycle; rom_address = latched address[ADDR_WIDTH-1:0]; busy=1; go READ.
- READ: rom_address held; capture rom_read_value into rdata<owner>; rvalid<owner>=1 for this cycle; go IDLE.
- Latency: req sampled in IDLE at edge N; gnt visible in cycle N+1; rvalid/rdata in cycle N+2. Max throughput: one read per 3 cycles.
- Requester must drop req in the cycle after seeing gnt. A req still high in IDLE is a new request.
- A req dropped before gnt is ignored; no transaction.
- Out of range: if latched address[7:ADDR_WIDTH] != 0, rdata<owner> = 0 and err<owner> = 1 with rvalid. The ROM is still addressed with the truncated bits but its data is discarded. With ADDR_WIDTH=8, err is never set.
- rdata0/rdata1 hold their last value until the next rvalid on that port. err* is a pulse and is 0 whenever the matching rvalid is 0.
- At most one of gnt0/gnt1 and one of rvalid0/rvalid1 is high in any cycle.
- Default arbitration is fixed priority: port 0 wins whenever req0=1. Port 1 can starve.

Optional Feature:
- Macro ROM_ARB_RR_EN.
- Defined: round-robin arbitration. A last-grant register, reset to 1, is updated on every grant. When both ports request in IDLE, the port not granted last wins, so the first contested grant after reset goes to port 0. A single requester always wins.
- Undefined: fixed priority to port 0 and no last-grant register.

Test Plan:
- Single read: ROM word[3]=16'hA55A, req0=1, addr0=8'h03 -> gnt0 at +1, rvalid0=1, rdata0=16'hA55A, err0=0 at +2; busy high for 2 cycles.
- Out of range: ADDR_WIDTH=4, req1 with addr1=8'h13 -> rvalid1=1, rdata1=16'h0000, err1=1; rdata0 unchanged.
- Contention, fixed priority: req0 and req1 held continuously -> only gnt0 ever pulses across 12 cycles. With ROM_ARB_RR_EN: grants alternate 0,1,0,1.
- Back-to-back: req0 re-asserted immediately after rvalid0 with addr0=8'h04 (word 16'h1234) -> next gnt0 3 cycles after previous gnt0, rdata0=16'h1234.
- Reset mid-operation: assert rst=0 in the GRANT cycle -> all outputs 0 immediately. After release, no rvalid appears until a new req.
- Withdrawn request: req1 pulsed high for one cycle while a port 0 transaction is busy -> no gnt1/rvalid1 after that transaction completes.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Purpose : shares one combinational program-ROM read port between port 0 (CPU fetch) and port 1 (debug scanner).
// Latency : req sampled in IDLE at edge N -> gnt in cycle N+1 -> rvalid/rdata/err in cycle N+2; one read per 3 cycles.
// Backpr. : requests are only sampled in IDLE; a requester holds req/addr until gnt, losing or late requests simply wait.
//
// Ports   : clk/rst (async active-low); per port reqX/addrX in, gntX/rvalidX/rdataX/errX out;
//           rom_address out / rom_read_value in to the ROM; busy = transaction in flight.
// Option  : define ROM_ARB_RR_EN for round-robin arbitration (default build is fixed priority to port 0).
module rom_port_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [7:0]            addr0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  err0,
    input  logic                  req1,
    input  logic [7:0]            addr1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  err1,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_read_value,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t     state_q;
    logic       owner_q;   // 0 = port 0, 1 = port 1
    logic       oor_q;     // latched address has bits above the ROM depth
    logic       win_d;
    logic [7:0] addr_sel_d;
    logic       oor_d;

`ifdef ROM_ARB_RR_EN
    logic       last_q;    // port granted most recently; reset to 1 so port 0 wins the first contest
`endif

    // Winner selection, only consumed in IDLE.
    always_comb begin
        win_d = 1'b0;
`ifdef ROM_ARB_RR_EN
        if (req0 && req1) begin
            win_d = ~last_q;
        end else begin
            win_d = req1;
        end
`else
        win_d = ~req0;
`endif
        addr_sel_d = win_d ? addr1 : addr0;
        // Shift form also works for ADDR_WIDTH = 8, where no upper bits exist.
        oor_d      = ((addr_sel_d >> ADDR_WIDTH) != 8'd0);
    end

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            oor_q       <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            rom_address <= '0;
`ifdef ROM_ARB_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            // Handshake outputs are single-cycle pulses by default.
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        owner_q     <= win_d;
                        oor_q       <= oor_d;
                        rom_address <= addr_sel_d[ADDR_WIDTH-1:0];
                        gnt0        <= ~win_d;
                        gnt1        <= win_d;
                        state_q     <= S_GRANT;
`ifdef ROM_ARB_RR_EN
                        last_q      <= win_d;
`endif
                    end
                end
                S_GRANT: begin
                    // rom_address has been stable for this whole cycle, so the ROM
                    // output is captured here and presented during READ.
                    if (owner_q) begin
                        rvalid1 <= 1'b1;
                        err1    <= oor_q;
                        rdata1  <= oor_q ? '0 : rom_read_value;
                    end else begin
                        rvalid0 <= 1'b1;
                        err0    <= oor_q;
                        rdata0  <= oor_q ? '0 : rom_read_value;
                    end
                    state_q <= S_READ;
                end
                S_READ: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Purpose : self-checking bench for rom_port_arbiter against a transaction-level schedule model.
// Latency : model predicts gnt one cycle and rvalid two cycles after an idle-edge request.
// Backpr. : driver holds req/addr until gnt, occasionally withdraws, and drops req after gnt.
module tb_rom_port_arbiter;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;
`ifdef ROM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1;
    logic [7:0]    addr0, addr1;
    logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] rom_address;
    logic [DW-1:0] rom_read_value;
    logic [DW-1:0] rom_mem [DEPTH];

    always #5 clk = ~clk;

    assign rom_read_value = rom_mem[rom_address];

    rom_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
        .rom_address(rom_address), .rom_read_value(rom_read_value), .busy(busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction schedule) ----------------
    bit [1:0]      m_gnt, m_rv, m_err;
    bit            m_busy;
    logic [DW-1:0] m_rdata [2];
    logic [AW-1:0] m_addr;
    int            m_left;      // remaining edges before the arbiter samples again
    bit            m_pend;
    int            m_pend_p;
    logic [DW-1:0] m_pend_dat;
    bit            m_pend_err;
    int            m_last;

    task automatic model_reset();
        m_gnt = '0; m_rv = '0; m_err = '0; m_busy = 1'b0;
        m_rdata[0] = '0; m_rdata[1] = '0; m_addr = '0;
        m_left = 0; m_pend = 1'b0; m_pend_p = 0; m_pend_dat = '0; m_pend_err = 1'b0;
        m_last = 1;
    endtask

    task automatic model_edge();
        int w;
        int a;
        bit oor;
        m_gnt = '0; m_rv = '0; m_err = '0;
        if (m_pend) begin
            m_rv[m_pend_p]    = 1'b1;
            m_err[m_pend_p]   = m_pend_err;
            m_rdata[m_pend_p] = m_pend_dat;
            m_pend = 1'b0;
        end
        if (m_left == 0 && (req0 || req1)) begin
            if (req0 && req1) w = RR ? (m_last == 0 ? 1 : 0) : 0;
            else              w = req1 ? 1 : 0;
            a          = (w == 1) ? int'(addr1) : int'(addr0);
            oor        = (a >= DEPTH);
            m_gnt[w]   = 1'b1;
            m_addr     = AW'(a % DEPTH);
            m_pend     = 1'b1;
            m_pend_p   = w;
            m_pend_err = oor;
            m_pend_dat = oor ? '0 : rom_mem[a % DEPTH];
            m_left     = 3;
            m_last     = w;
        end
        m_busy = (m_left >= 2);
        if (m_left > 0) m_left--;
    endtask

    task automatic check_outputs();
        chk("gnt0",    gnt0,    m_gnt[0]);
        chk("gnt1",    gnt1,    m_gnt[1]);
        chk("rvalid0", rvalid0, m_rv[0]);
        chk("rvalid1", rvalid1, m_rv[1]);
        chk("err0",    err0,    m_err[0]);
        chk("err1",    err1,    m_err[1]);
        chk("rdata0",  rdata0,  m_rdata[0]);
        chk("rdata1",  rdata1,  m_rdata[1]);
        chk("busy",    busy,    m_busy);
        chk("rom_address", rom_address, m_addr);
    endtask

    // One clock: model sees the same inputs the DUT samples, outputs checked 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge();
        #1;
        check_outputs();
    endtask

    int gnt1_seen;

    initial begin
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = DW'($urandom);
        rom_mem[3] = 16'hA55A;
        rom_mem[4] = 16'h1234;

        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        model_reset();
        #2;
        check_outputs();
        step(); step();
        #2 rst = 1'b1;
        step();

        // Single read of word 3, then back-to-back read of word 4.
        req0 = 1'b1; addr0 = 8'h03;
        step();
        req0 = 1'b0;
        step();
        chk("single_rdata0", rdata0, 16'hA55A);
        req0 = 1'b1; addr0 = 8'h04;
        step();
        step();
        chk("b2b_gnt0", gnt0, 1'b1);
        req0 = 1'b0;
        step();
        chk("b2b_rdata0", rdata0, 16'h1234);
        step();

        // Out-of-range address on port 1.
        req1 = 1'b1; addr1 = 8'h13;
        step();
        req1 = 1'b0;
        step();
        chk("oor_err1",   err1,   1'b1);
        chk("oor_rdata1", rdata1, 16'h0000);
        chk("oor_rdata0_held", rdata0, 16'h1234);
        step();

        // Continuous contention for 12 cycles.
        req0 = 1'b1; addr0 = 8'h01; req1 = 1'b1; addr1 = 8'h02;
        gnt1_seen = 0;
        repeat (12) begin
            step();
            if (gnt1) gnt1_seen++;
        end
        chk("contend_gnt1_count", gnt1_seen, RR ? 2 : 0);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) step();

        // Port 1 request withdrawn while port 0 is busy.
        req0 = 1'b1; addr0 = 8'h05;
        step();
        req0 = 1'b0; req1 = 1'b1; addr1 = 8'h06;
        step();
        req1 = 1'b0;
        repeat (4) step();

        // Reset asserted during the GRANT cycle.
        req0 = 1'b1; addr0 = 8'h03;
        step();
        req0 = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #3;
        step();
        #2 rst = 1'b1;
        repeat (4) step();

        // Randomized traffic.
        repeat (400) begin
            step();
            if (req0) begin
                if (m_gnt[0])                     req0 = 1'b0;
                else if ($urandom_range(0, 7) == 0) req0 = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                req0 = 1'b1; addr0 = 8'($urandom_range(0, 23));
            end
            if (req1) begin
                if (m_gnt[1])                     req1 = 1'b0;
                else if ($urandom_range(0, 7) == 0) req1 = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                req1 = 1'b1; addr1 = 8'($urandom_range(0, 23));
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
